// File: rtl/cyclic_prefix_removal_if.sv
// Sample-stream bundle for cyclic_prefix_removal: upstream s_* beats in, framed m_* beats out.
// master = surrounding environment (source + sink), slave = the CP removal block.
interface cyclic_prefix_removal_if #(
  parameter int IDX_WIDTH = 8
);
  logic                 s_valid;
  logic                 s_ready;
  logic [31:0]          s_data;
  logic                 s_last;
  logic                 m_valid;
  logic                 m_ready;
  logic [31:0]          m_data;
  logic                 m_last;
  logic                 m_trunc;
  logic [IDX_WIDTH-1:0] m_index;

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_last, m_trunc, m_index
  );

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_last, m_trunc, m_index
  );
endinterface

// File: rtl/cyclic_prefix_removal.sv
// Drops CP_LEN prefix samples and forwards FFT_LEN body samples per OFDM symbol, tagging frames.
// Optional frame/truncation statistics counters are enabled with `define CP_REMOVAL_STATS_EN.
//
// state   | meaning
// ST_CP   | discarding cyclic-prefix samples, input always ready
// ST_BODY | forwarding body samples through the single output register
module cyclic_prefix_removal #(
  parameter int FFT_LEN   = 64,
  parameter int CP_LEN    = 16,
  parameter int IDX_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  cyclic_prefix_removal_if.slave   bus
`ifdef CP_REMOVAL_STATS_EN
  ,
  output logic [31:0]              stat_frames,
  output logic [15:0]              stat_trunc
`endif
);

  localparam int MAX_LEN = (FFT_LEN > CP_LEN) ? FFT_LEN : CP_LEN;
  localparam int CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic {ST_CP, ST_BODY} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_WIDTH-1:0] idx_q, idx_d;
  logic                 m_valid_q, m_valid_d;
  logic [31:0]          m_data_q, m_data_d;
  logic                 m_last_q, m_last_d;
  logic                 m_trunc_q, m_trunc_d;
  logic [IDX_WIDTH-1:0] m_index_q, m_index_d;

  logic ready_int;
  logic take;
  logic cp_end;
  logic body_end;

  // CP samples are always dropped, so only the body path sees backpressure.
  assign ready_int = (state_q == ST_CP) | ~m_valid_q | bus.m_ready;
  assign take      = bus.s_valid & ready_int;
  assign cp_end    = (cnt_q == CNT_W'(CP_LEN - 1));
  assign body_end  = (cnt_q == CNT_W'(FFT_LEN - 1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    m_trunc_d = m_trunc_q;
    m_index_d = m_index_q;

    if (m_valid_q && bus.m_ready) begin
      m_valid_d = 1'b0;
    end

    case (state_q)
      ST_CP: begin
        if (take) begin
          if (bus.s_last) begin
            cnt_d = '0;
            idx_d = '0;
          end else if (cp_end) begin
            state_d = ST_BODY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_BODY: begin
        if (take) begin
          m_valid_d = 1'b1;
          m_data_d  = bus.s_data;
          m_last_d  = bus.s_last | body_end;
          m_trunc_d = bus.s_last & ~body_end;
          m_index_d = idx_q;
          if (bus.s_last || body_end) begin
            state_d = ST_CP;
            cnt_d   = '0;
            // burst end dominates the per-symbol increment
            idx_d   = bus.s_last ? '0 : idx_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_CP;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_CP;
      cnt_q     <= '0;
      idx_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
      m_trunc_q <= 1'b0;
      m_index_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
      m_trunc_q <= m_trunc_d;
      m_index_q <= m_index_d;
    end
  end

  assign bus.s_ready = resetn & ready_int;
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign bus.m_last  = m_last_q;
  assign bus.m_trunc = m_trunc_q;
  assign bus.m_index = m_index_q;

`ifdef CP_REMOVAL_STATS_EN
  logic [31:0] stat_frames_q, stat_frames_d;
  logic [15:0] stat_trunc_q, stat_trunc_d;
  logic        frame_done;

  assign frame_done = m_valid_q & bus.m_ready & m_last_q;

  always_comb begin
    stat_frames_d = stat_frames_q;
    stat_trunc_d  = stat_trunc_q;
    if (frame_done && !m_trunc_q && (stat_frames_q != '1)) begin
      stat_frames_d = stat_frames_q + 1'b1;
    end
    if (frame_done && m_trunc_q && (stat_trunc_q != '1)) begin
      stat_trunc_d = stat_trunc_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stat_frames_q <= '0;
      stat_trunc_q  <= '0;
    end else begin
      stat_frames_q <= stat_frames_d;
      stat_trunc_q  <= stat_trunc_d;
    end
  end

  assign stat_frames = stat_frames_q;
  assign stat_trunc  = stat_trunc_q;
`endif

endmodule

// File: tb/tb_cyclic_prefix_removal.sv
// Directed bench for cyclic_prefix_removal: default instance plus a small
// FFT_LEN=4/CP_LEN=2/IDX_WIDTH=2 instance sharing the same input stream for index wrap.
module tb_cyclic_prefix_removal;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  cyclic_prefix_removal_if #(.IDX_WIDTH(8)) if1 ();
  cyclic_prefix_removal_if #(.IDX_WIDTH(2)) if2 ();

`ifdef CP_REMOVAL_STATS_EN
  logic [31:0] st_frames1, st_frames2;
  logic [15:0] st_trunc1, st_trunc2;
`endif

  cyclic_prefix_removal #(.FFT_LEN(64), .CP_LEN(16), .IDX_WIDTH(8)) dut (
    .clk(clk), .resetn(resetn), .bus(if1)
`ifdef CP_REMOVAL_STATS_EN
    , .stat_frames(st_frames1), .stat_trunc(st_trunc1)
`endif
  );

  cyclic_prefix_removal #(.FFT_LEN(4), .CP_LEN(2), .IDX_WIDTH(2)) dut_small (
    .clk(clk), .resetn(resetn), .bus(if2)
`ifdef CP_REMOVAL_STATS_EN
    , .stat_frames(st_frames2), .stat_trunc(st_trunc2)
`endif
  );

  assign if2.s_valid = if1.s_valid;
  assign if2.s_data  = if1.s_data;
  assign if2.s_last  = if1.s_last;
  assign if2.m_ready = if1.m_ready;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int rdy_mode = 0;
  int stall_err = 0;

  logic [41:0] obs1[$];
  logic [41:0] obs2[$];
  logic [41:0] exp_q[$];
  logic [41:0] cur1;
  logic [41:0] hold_w;
  logic        hold_pend = 1'b0;

  assign cur1 = {if1.m_last, if1.m_trunc, if1.m_index, if1.m_data};

  always @(negedge clk) begin
    if (resetn && if1.m_valid && if1.m_ready) obs1.push_back(cur1);
    if (resetn && if2.m_valid && if2.m_ready)
      obs2.push_back({if2.m_last, if2.m_trunc, 6'd0, if2.m_index, if2.m_data});
  end

  // Output must hold steady across any cycle where it was offered but not taken.
  always @(negedge clk) begin
    if (!resetn) begin
      hold_pend <= 1'b0;
    end else begin
      if (hold_pend && !(if1.m_valid && cur1 == hold_w)) stall_err <= stall_err + 1;
      hold_pend <= if1.m_valid & ~if1.m_ready;
      hold_w    <= cur1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rdy_mode == 1) if1.m_ready = ~if1.m_ready;
    else if1.m_ready = 1'b1;
  endtask

  task automatic apply_reset();
    if1.s_valid = 1'b0;
    if1.s_last  = 1'b0;
    if1.s_data  = '0;
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    tick();
    obs1.delete();
    obs2.delete();
    exp_q.delete();
  endtask

  task automatic send_sample(input int d, input bit last);
    bit acc;
    acc = 1'b0;
    if1.s_valid = 1'b1;
    if1.s_data  = 32'(d);
    if1.s_last  = last;
    for (int w = 0; w < 64 && !acc; w++) begin
      @(negedge clk);
      acc = if1.s_ready;
      tick();
    end
    if (!acc) begin
      cmp_cnt++;
      err_cnt++;
      $display("FAIL send_timeout: data %0d not accepted, required accept within 64 cycles", d);
    end
  endtask

  task automatic send_run(input int first, input int count, input int last_pos);
    for (int k = 0; k < count; k++) send_sample(first + k, (k == last_pos));
    if1.s_valid = 1'b0;
    if1.s_last  = 1'b0;
  endtask

  task automatic drain();
    if1.s_valid = 1'b0;
    if1.s_last  = 1'b0;
    repeat (12) tick();
  endtask

  task automatic exp_frame(input int first, input int n, input bit trunc, input int idx);
    for (int k = 0; k < n; k++)
      exp_q.push_back({(k == n - 1), (trunc && k == n - 1), 8'(idx), 32'(first + k)});
  endtask

  task automatic test_reset();
    if1.s_valid = 1'b0;
    if1.s_last  = 1'b0;
    if1.s_data  = '0;
    if1.m_ready = 1'b1;
    resetn = 1'b0;
    #1;
    cmp_cnt++; if (if1.m_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_m_valid: got %b required 0", if1.m_valid); end
    cmp_cnt++; if (if1.m_data !== 32'd0) begin err_cnt++; $display("FAIL reset_m_data: got %h required 0", if1.m_data); end
    cmp_cnt++; if (if1.m_last !== 1'b0) begin err_cnt++; $display("FAIL reset_m_last: got %b required 0", if1.m_last); end
    cmp_cnt++; if (if1.m_trunc !== 1'b0) begin err_cnt++; $display("FAIL reset_m_trunc: got %b required 0", if1.m_trunc); end
    cmp_cnt++; if (if1.m_index !== 8'd0) begin err_cnt++; $display("FAIL reset_m_index: got %0d required 0", if1.m_index); end
    cmp_cnt++; if (if1.s_ready !== 1'b0) begin err_cnt++; $display("FAIL reset_s_ready: got %b required 0", if1.s_ready); end
    apply_reset();
    cmp_cnt++; if (if1.s_ready !== 1'b1) begin err_cnt++; $display("FAIL reset_cp_ready: got %b required 1", if1.s_ready); end
  endtask

  task automatic test_full_rate();
    rdy_mode = 0;
    apply_reset();
    send_run(0, 160, -1);
    drain();
    exp_frame(16, 64, 1'b0, 0);
    exp_frame(96, 64, 1'b0, 1);
    cmp_cnt++;
    if (obs1.size() !== exp_q.size()) begin err_cnt++; $display("FAIL full_rate_count: got %0d required %0d", obs1.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < obs1.size(); k++) begin
      cmp_cnt++;
      if (obs1[k] !== exp_q[k]) begin err_cnt++; $display("FAIL full_rate_item%0d: got %h required %h", k, obs1[k], exp_q[k]); end
    end
`ifdef CP_REMOVAL_STATS_EN
    cmp_cnt++; if (st_frames1 !== 32'd2) begin err_cnt++; $display("FAIL full_rate_stat_frames: got %0d required 2", st_frames1); end
    cmp_cnt++; if (st_trunc1 !== 16'd0) begin err_cnt++; $display("FAIL full_rate_stat_trunc: got %0d required 0", st_trunc1); end
`endif
  endtask

  task automatic test_backpressure();
    rdy_mode = 1;
    apply_reset();
    stall_err = 0;
    send_run(0, 160, -1);
    drain();
    rdy_mode = 0;
    tick();
    exp_frame(16, 64, 1'b0, 0);
    exp_frame(96, 64, 1'b0, 1);
    cmp_cnt++;
    if (obs1.size() !== exp_q.size()) begin err_cnt++; $display("FAIL backpressure_count: got %0d required %0d", obs1.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < obs1.size(); k++) begin
      cmp_cnt++;
      if (obs1[k] !== exp_q[k]) begin err_cnt++; $display("FAIL backpressure_item%0d: got %h required %h", k, obs1[k], exp_q[k]); end
    end
    cmp_cnt++;
    if (stall_err !== 0) begin err_cnt++; $display("FAIL backpressure_hold: got %0d unstable stall cycles required 0", stall_err); end
  endtask

  task automatic test_trunc();
    rdy_mode = 0;
    apply_reset();
    send_run(0, 121, 120);
    send_run(1000, 80, -1);
    drain();
    exp_frame(16, 64, 1'b0, 0);
    exp_frame(96, 25, 1'b1, 1);
    exp_frame(1016, 64, 1'b0, 0);
    cmp_cnt++;
    if (obs1.size() !== exp_q.size()) begin err_cnt++; $display("FAIL trunc_count: got %0d required %0d", obs1.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < obs1.size(); k++) begin
      cmp_cnt++;
      if (obs1[k] !== exp_q[k]) begin err_cnt++; $display("FAIL trunc_item%0d: got %h required %h", k, obs1[k], exp_q[k]); end
    end
`ifdef CP_REMOVAL_STATS_EN
    cmp_cnt++; if (st_frames1 !== 32'd2) begin err_cnt++; $display("FAIL trunc_stat_frames: got %0d required 2", st_frames1); end
    cmp_cnt++; if (st_trunc1 !== 16'd1) begin err_cnt++; $display("FAIL trunc_stat_trunc: got %0d required 1", st_trunc1); end
`endif
  endtask

  task automatic test_cp_last();
    rdy_mode = 0;
    apply_reset();
    send_run(0, 80, -1);
    send_run(500, 11, 10);
    send_run(600, 80, -1);
    drain();
    exp_frame(16, 64, 1'b0, 0);
    exp_frame(616, 64, 1'b0, 0);
    cmp_cnt++;
    if (obs1.size() !== exp_q.size()) begin err_cnt++; $display("FAIL cp_last_count: got %0d required %0d", obs1.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < obs1.size(); k++) begin
      cmp_cnt++;
      if (obs1[k] !== exp_q[k]) begin err_cnt++; $display("FAIL cp_last_item%0d: got %h required %h", k, obs1[k], exp_q[k]); end
    end
  endtask

  task automatic test_final_last();
    rdy_mode = 0;
    apply_reset();
    send_run(0, 160, 159);
    send_run(300, 80, -1);
    drain();
    exp_frame(16, 64, 1'b0, 0);
    exp_frame(96, 64, 1'b0, 1);
    exp_frame(316, 64, 1'b0, 0);
    cmp_cnt++;
    if (obs1.size() !== exp_q.size()) begin err_cnt++; $display("FAIL final_last_count: got %0d required %0d", obs1.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < obs1.size(); k++) begin
      cmp_cnt++;
      if (obs1[k] !== exp_q[k]) begin err_cnt++; $display("FAIL final_last_item%0d: got %h required %h", k, obs1[k], exp_q[k]); end
    end
  endtask

  task automatic test_index_wrap();
    rdy_mode = 0;
    apply_reset();
    send_run(0, 30, -1);
    drain();
    for (int s = 0; s < 5; s++) exp_frame(6 * s + 2, 4, 1'b0, s % 4);
    cmp_cnt++;
    if (obs2.size() !== exp_q.size()) begin err_cnt++; $display("FAIL index_wrap_count: got %0d required %0d", obs2.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < obs2.size(); k++) begin
      cmp_cnt++;
      if (obs2[k] !== exp_q[k]) begin err_cnt++; $display("FAIL index_wrap_item%0d: got %h required %h", k, obs2[k], exp_q[k]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    rdy_mode = 0;
    apply_reset();
    send_run(0, 20, -1);
    cmp_cnt++;
    if (if1.m_valid !== 1'b1) begin err_cnt++; $display("FAIL midreset_pre_valid: got %b required 1", if1.m_valid); end
    resetn = 1'b0;
    #1;
    cmp_cnt++; if (if1.m_valid !== 1'b0) begin err_cnt++; $display("FAIL midreset_m_valid: got %b required 0", if1.m_valid); end
    cmp_cnt++; if (if1.s_ready !== 1'b0) begin err_cnt++; $display("FAIL midreset_s_ready: got %b required 0", if1.s_ready); end
`ifdef CP_REMOVAL_STATS_EN
    cmp_cnt++; if (st_frames1 !== 32'd0) begin err_cnt++; $display("FAIL midreset_stat_frames: got %0d required 0", st_frames1); end
    cmp_cnt++; if (st_trunc1 !== 16'd0) begin err_cnt++; $display("FAIL midreset_stat_trunc: got %0d required 0", st_trunc1); end
`endif
    tick();
    resetn = 1'b1;
    tick();
    obs1.delete();
    exp_q.delete();
    send_run(200, 80, -1);
    drain();
    exp_frame(216, 64, 1'b0, 0);
    cmp_cnt++;
    if (obs1.size() !== exp_q.size()) begin err_cnt++; $display("FAIL midreset_count: got %0d required %0d", obs1.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < obs1.size(); k++) begin
      cmp_cnt++;
      if (obs1[k] !== exp_q[k]) begin err_cnt++; $display("FAIL midreset_item%0d: got %h required %h", k, obs1[k], exp_q[k]); end
    end
  endtask

  initial begin
    test_reset();
    test_full_rate();
    test_backpressure();
    test_trunc();
    test_cp_last();
    test_final_last();
    test_index_wrap();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
